// File: rtl/rtc_pkg.sv
// rtc_pkg: shared state encoding, timer width and phase sequencing for the RTC bus sequencers.
// Rev 1.0
`default_nettype none

package rtc_pkg;

  localparam int RTC_PHASE_CYC_DEFAULT = 4;
  localparam int RTC_TIMER_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ADDR_SETUP = 3'd1,
    ST_ADDR_WR    = 3'd2,
    ST_ADDR_HOLD  = 3'd3,
    ST_DATA_SETUP = 3'd4,
    ST_DATA_RD    = 3'd5,
    ST_DATA_HOLD  = 3'd6,
    ST_DONE       = 3'd7
  } rtc_state_t;

  // Successor of a timed bus phase; the last timed phase hands over to DONE.
  function automatic rtc_state_t rtc_next_phase(input rtc_state_t st);
    rtc_state_t nxt;
    nxt = ST_IDLE;
    case (st)
      ST_ADDR_SETUP: nxt = ST_ADDR_WR;
      ST_ADDR_WR:    nxt = ST_ADDR_HOLD;
      ST_ADDR_HOLD:  nxt = ST_DATA_SETUP;
      ST_DATA_SETUP: nxt = ST_DATA_RD;
      ST_DATA_RD:    nxt = ST_DATA_HOLD;
      ST_DATA_HOLD:  nxt = ST_DONE;
      default:       nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: down-counter that measures one bus phase; expire is high on the phase's last cycle.
// Rev 1.0
`default_nettype none

module rtc_phase_timer
  import rtc_pkg::*;
#(
  parameter int WIDTH = RTC_TIMER_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

`default_nettype wire

// File: rtl/rtc_bus_reader.sv
// rtc_bus_reader: one-byte read sequencer for a multiplexed-AD RTC bus, all pins registered.
// Rev 1.0
`default_nettype none

module rtc_bus_reader
  import rtc_pkg::*;
#(
  parameter int PHASE_CYC = RTC_PHASE_CYC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] addr,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a_d
);

  localparam logic [RTC_TIMER_W-1:0] PHASE_LOAD = RTC_TIMER_W'(PHASE_CYC - 1);

  rtc_state_t state, state_nxt;
  logic [7:0] addr_q, addr_nxt;
  logic       timer_load, timer_tick, timer_expire, capture;

  logic       cs_n_nxt, wr_n_nxt, rd_n_nxt, a_d_nxt, ad_oe_nxt, busy_nxt, done_nxt;
  logic [7:0] ad_out_nxt;

  rtc_phase_timer #(
    .WIDTH(RTC_TIMER_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .load_val(PHASE_LOAD),
    .tick    (timer_tick),
    .expire  (timer_expire)
  );

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    timer_load = 1'b0;
    timer_tick = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_ADDR_SETUP;
          addr_nxt   = addr;
          timer_load = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: begin
        if (timer_expire) begin
          state_nxt  = rtc_next_phase(state);
          timer_load = (state != ST_DATA_HOLD);
          capture    = (state == ST_DATA_RD);
        end else begin
          timer_tick = 1'b1;
        end
      end
    endcase
  end

  // Pin values are decoded from the upcoming state so the registered pins line up with it.
  always_comb begin
    cs_n_nxt   = 1'b1;
    wr_n_nxt   = 1'b1;
    rd_n_nxt   = 1'b1;
    a_d_nxt    = 1'b0;
    ad_oe_nxt  = 1'b0;
    ad_out_nxt = 8'h00;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    case (state_nxt)
      ST_ADDR_SETUP, ST_ADDR_WR, ST_ADDR_HOLD: begin
        cs_n_nxt   = 1'b0;
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = addr_nxt;
        busy_nxt   = 1'b1;
        wr_n_nxt   = (state_nxt != ST_ADDR_WR);
      end
      ST_DATA_SETUP, ST_DATA_RD, ST_DATA_HOLD: begin
        cs_n_nxt = 1'b0;
        a_d_nxt  = 1'b1;
        busy_nxt = 1'b1;
        rd_n_nxt = (state_nxt != ST_DATA_RD);
      end
      ST_DONE: done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      addr_q   <= 8'h00;
      data_out <= 8'h00;
      cs_n     <= 1'b1;
      wr_n     <= 1'b1;
      rd_n     <= 1'b1;
      a_d      <= 1'b0;
      ad_oe    <= 1'b0;
      ad_out   <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      cs_n   <= cs_n_nxt;
      wr_n   <= wr_n_nxt;
      rd_n   <= rd_n_nxt;
      a_d    <= a_d_nxt;
      ad_oe  <= ad_oe_nxt;
      ad_out <= ad_out_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      if (capture) begin
        data_out <= ad_in;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_reader.sv
// tb_rtc_bus_reader: directed and random read cycles against a cycle-offset reference model.
// Rev 1.0
`default_nettype none

module tb_rtc_bus_reader;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset_n, start;
  logic [7:0] addr, ad_in;
  logic       busy, done, ad_oe, cs_n, wr_n, rd_n, a_d;
  logic [7:0] data_out, ad_out;

  always #5 clk = ~clk;

  rtc_bus_reader #(.PHASE_CYC(P)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .addr(addr),
    .busy(busy), .done(done), .data_out(data_out), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a_d(a_d)
  );

  int tests = 0, fails = 0;
  // Model: m_off = cycles since the accepting edge (-1 when idle and able to accept).
  int         m_off  = -1;
  logic [7:0] m_addr = 8'h00, m_data = 8'h00;
  int done_seen = 0, wr_lo = 0, rd_lo = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      m_off  = -1;
      m_data = 8'h00;
    end else if (m_off < 0) begin
      if (start) begin
        m_off  = 0;
        m_addr = addr;
      end
    end else begin
      if (m_off == 5*P-1) m_data = ad_in;
      m_off = (m_off == 6*P) ? -1 : m_off + 1;
    end
  endtask

  task automatic check_outputs();
    bit busy_e, done_e;
    int ph;
    busy_e = (m_off >= 0) && (m_off < 6*P);
    done_e = (m_off == 6*P);
    ph     = busy_e ? m_off / P : -1;
    chk("busy",  int'(busy),  int'(busy_e));
    chk("done",  int'(done),  int'(done_e));
    chk("cs_n",  int'(cs_n),  int'(!busy_e));
    chk("wr_n",  int'(wr_n),  int'(ph != 1));
    chk("rd_n",  int'(rd_n),  int'(ph != 4));
    chk("ad_oe", int'(ad_oe), int'(busy_e && ph < 3));
    if (busy_e) chk("a_d", int'(a_d), int'(ph >= 3));
    if (busy_e && ph < 3) chk("ad_out", int'(ad_out), int'(m_addr));
    chk("data_out", int'(data_out), int'(m_data));
    chk("bus_protocol", int'((ad_oe && !rd_n) || (!wr_n && !rd_n)), 0);
    if (done)  done_seen++;
    if (!wr_n) wr_lo++;
    if (!rd_n) rd_lo++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, last_done, gap_cnt;
    bit in_gap;

    reset_n = 1'b0; start = 1'b0; addr = 8'h00; ad_in = 8'h00;
    repeat (3) step();
    chk("rst_ad_out", int'(ad_out), 0);
    chk("rst_a_d",    int'(a_d),    0);
    reset_n = 1'b1;
    step();

    // Basic read: addr 0x21, pad returns 0x59.
    wr_lo = 0; rd_lo = 0;
    start = 1'b1; addr = 8'h21; ad_in = 8'h59;
    step();
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (done && lat < 0) lat = n + 1;
    end
    chk("done_latency", lat, 6*P+1);
    chk("wr_low_cycles", wr_lo, P);
    chk("rd_low_cycles", rd_lo, P);
    chk("read_data", int'(data_out), 8'h59);

    // Capture happens on the last DATA_RD cycle only.
    start = 1'b1; addr = 8'($urandom); ad_in = 8'h00;
    step();
    start = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (m_off == 5*P-1)                    ad_in = 8'h33;
      else if (m_off >= 5*P && m_off < 6*P)  ad_in = 8'hAA;
      else                                   ad_in = 8'h00;
      step();
    end
    chk("capture_edge", int'(data_out), 8'h33);

    // Starts during ADDR_WR and DONE are ignored.
    base = done_seen;
    start = 1'b1; addr = 8'h5C; ad_in = 8'h17;
    step();
    for (int n = 0; n < 32; n++) begin
      start = (m_off == P) || (m_off == 6*P);
      step();
    end
    start = 1'b0;
    chk("ignored_start_done_count", done_seen - base, 1);

    // One-cycle reset in DATA_RD aborts the read.
    start = 1'b1; addr = 8'h3E; ad_in = 8'hC4;
    step();
    start = 1'b0;
    for (int n = 0; n < 40 && m_off != 4*P+1; n++) step();
    chk("reached_data_rd", m_off, 4*P+1);
    base = done_seen;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort_strobes", int'({cs_n, wr_n, rd_n}), 3'b111);
    chk("abort_ad_oe",   int'(ad_oe), 0);
    repeat (30) step();
    chk("abort_no_done", done_seen - base, 0);
    chk("abort_data",    int'(data_out), 0);

    // Start held high: back-to-back reads with cs_n released in between.
    start = 1'b1; addr = 8'h42; ad_in = 8'h9D;
    last_done = -1; in_gap = 1'b0; gap_cnt = 0;
    for (int i = 0; i < 90; i++) begin
      step();
      if (in_gap) begin
        if (cs_n) gap_cnt++;
        else begin
          chk("cs_gap", int'(gap_cnt >= 1), 1);
          in_gap = 1'b0;
        end
      end
      if (done) begin
        if (last_done >= 0) chk("done_period", i - last_done, 6*P+2);
        last_done = i;
        in_gap    = 1'b1;
        gap_cnt   = cs_n ? 1 : 0;
      end
    end
    start = 1'b0;
    repeat (30) step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      start   = ($urandom_range(0, 9) == 0);
      addr    = 8'($urandom);
      ad_in   = 8'($urandom);
      reset_n = ($urandom_range(0, 199) != 0);
      step();
    end
    reset_n = 1'b1; start = 1'b0;
    repeat (30) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
